// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for imm_gen_pipe: upstream instruction beat in, extended immediate beat out.
// The slave modport is the immediate generator's view; master is the surrounding pipeline.
interface imm_gen_pipe_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [24:0]      instr;
  logic [2:0]       imm_src;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  imm_ext;
  logic             imm_illegal;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  in_valid, instr, imm_src, in_tag, out_ready,
    output in_ready, out_valid, imm_ext, imm_illegal, out_tag
  );

  modport master (
    output in_valid, instr, imm_src, in_tag, out_ready,
    input  in_ready, out_valid, imm_ext, imm_illegal, out_tag
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator (I/S/B/U/J/zimm) with a main + skid register pair so that
// in_ready is a flop output and full throughput is kept under backpressure.
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  imm_gen_pipe_if.slave bus
);

  if (!(XLEN == 32 || XLEN == 64)) begin : g_xlen_check
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } beat_t;

  logic        sgn;
  logic [31:0] imm32;
  logic        ill;
  beat_t       beat_in;

  // bus.instr[k] is instruction bit k+7.
  assign sgn = bus.instr[24];

  always_comb begin
    imm32 = '0;
    ill   = 1'b0;
    case (bus.imm_src)
      3'b000: imm32 = {{20{sgn}}, bus.instr[24:13]};
      3'b001: imm32 = {{20{sgn}}, bus.instr[24:18], bus.instr[4:0]};
      3'b010: imm32 = {{19{sgn}}, sgn, bus.instr[0], bus.instr[23:18], bus.instr[4:1], 1'b0};
      3'b011: imm32 = {bus.instr[24:5], 12'b0};
      3'b100: imm32 = {{11{sgn}}, sgn, bus.instr[12:5], bus.instr[13], bus.instr[23:14], 1'b0};
      3'b101: imm32 = {27'b0, bus.instr[12:8]};
      default: ill = 1'b1;
    endcase
  end

  always_comb begin
    beat_in.imm = XLEN'($signed(imm32));
    beat_in.ill = ill;
    beat_in.tag = bus.in_tag;
  end

  logic  m_valid_q, m_valid_d;
  logic  k_valid_q, k_valid_d;
  logic  in_ready_q, in_ready_d;
  beat_t m_q, m_d;
  beat_t k_q, k_d;
  logic  accept;
  logic  m_stall;

  assign accept  = bus.in_valid & in_ready_q;
  assign m_stall = m_valid_q & ~bus.out_ready;

  always_comb begin
    m_valid_d = m_valid_q;
    k_valid_d = k_valid_q;
    m_d       = m_q;
    k_d       = k_q;
    if (flush_i) begin
      m_valid_d = 1'b0;
      k_valid_d = 1'b0;
    end else if (m_stall) begin
      if (accept) begin
        k_valid_d = 1'b1;
        k_d       = beat_in;
      end
    end else if (k_valid_q) begin
      // in_ready is low while K holds a beat, so nothing new arrives here.
      m_valid_d = 1'b1;
      m_d       = k_q;
      k_valid_d = 1'b0;
    end else begin
      m_valid_d = accept;
      if (accept) begin
        m_d = beat_in;
      end
    end
    in_ready_d = ~k_valid_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_valid_q  <= 1'b0;
      k_valid_q  <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      m_valid_q  <= m_valid_d;
      k_valid_q  <= k_valid_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Payload flops carry no reset; outputs are masked by m_valid_q instead.
  always_ff @(posedge clk_i) begin
    m_q <= m_d;
    k_q <= k_d;
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = m_valid_q;
  assign bus.imm_ext     = m_valid_q ? m_q.imm : '0;
  assign bus.imm_illegal = m_valid_q & m_q.ill;
  assign bus.out_tag     = m_valid_q ? m_q.tag : '0;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus; a queue-based model
// checks every output cycle while directed sequences cover decode, stall, flush and reset.
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(32)) b32 ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(32)) b64 ();

  assign b64.in_valid  = b32.in_valid;
  assign b64.instr     = b32.instr;
  assign b64.imm_src   = b32.imm_src;
  assign b64.in_tag    = b32.in_tag;
  assign b64.out_ready = b32.out_ready;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) u_dut32 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .flush_i(flush),
    .bus    (b32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) u_dut64 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .flush_i(flush),
    .bus    (b64)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint fld(input logic [31:0] ins, input int lo, input int n);
    return longint'((ins >> lo) & ((32'd1 << n) - 32'd1));
  endfunction

  // Reference: immediates rebuilt arithmetically from the full 32-bit instruction word.
  function automatic longint ref_imm(input logic [31:0] ins, input logic [2:0] src,
                                     output logic illegal);
    longint sx;
    longint hi;
    sx      = longint'($signed(ins));
    illegal = 1'b0;
    case (src)
      3'd0: return sx >>> 20;
      3'd1: begin hi = sx >>> 25; return (hi << 5) | fld(ins, 7, 5); end
      3'd2: begin
        hi = sx >>> 31;
        return (hi << 12) | (fld(ins, 7, 1) << 11) | (fld(ins, 25, 6) << 5) | (fld(ins, 8, 4) << 1);
      end
      3'd3: return sx & ~longint'(64'hFFF);
      3'd4: begin
        hi = sx >>> 31;
        return (hi << 20) | (fld(ins, 12, 8) << 12) | (fld(ins, 20, 1) << 11)
             | (fld(ins, 21, 10) << 1);
      end
      3'd5: return fld(ins, 15, 5);
      default: begin illegal = 1'b1; return 0; end
    endcase
  endfunction

  typedef struct {
    logic [63:0] imm;
    logic        ill;
    logic [31:0] tag;
  } exp_t;

  exp_t q[$];
  int   since_rst = 0;

  // Scoreboard, sampled mid-low-phase after the drivers have settled.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        q.delete();
        since_rst = 0;
      end else begin
        exp_t   e;
        longint v;
        logic   il;
        if (since_rst < 2) since_rst++;
        if (since_rst >= 2) chk("in_ready_vs_occupancy", b32.in_ready, q.size() < 2);
        chk("valid64_eq_valid32", b64.out_valid, b32.out_valid);
        if (b32.out_valid) begin
          if (q.size() == 0) begin
            chk("spurious_out_valid", b32.out_valid, 0);
          end else begin
            chk("mon_imm32", b32.imm_ext, q[0].imm[31:0]);
            chk("mon_imm64", b64.imm_ext, q[0].imm);
            chk("mon_ill", {b64.imm_illegal, b32.imm_illegal}, {q[0].ill, q[0].ill});
            chk("mon_tag", b32.out_tag, q[0].tag);
          end
        end else begin
          chk("idle_outputs_zero", {b32.imm_ext, b32.out_tag} | b64.imm_ext, 0);
          chk("idle_ill_zero", {b64.imm_illegal, b32.imm_illegal}, 0);
        end
        if (flush) begin
          q.delete();
        end else begin
          if (b32.out_valid && b32.out_ready && q.size() > 0) void'(q.pop_front());
          if (b32.in_valid && b32.in_ready) begin
            v     = ref_imm({b32.instr, 7'b0}, b32.imm_src, il);
            e.imm = v;
            e.ill = il;
            e.tag = b32.in_tag;
            q.push_back(e);
          end
        end
      end
    end
  end

  typedef struct {
    logic [31:0] ins;
    logic [2:0]  src;
    logic [31:0] exp;
    logic        ill;
  } vec_t;

  vec_t vecs[13];

  task automatic offer(input logic [31:0] ins, input logic [2:0] src, input logic [31:0] tag);
    b32.in_valid = 1'b1;
    b32.instr    = ins[31:7];
    b32.imm_src  = src;
    b32.in_tag   = tag;
  endtask

  initial begin
    int          next_tag;
    int          nout;
    int          acc;
    int          cyc;
    logic [31:0] rx[$];
    logic [31:0] ev;

    vecs[0]  = '{32'hFFF00093, 3'd0, 32'hFFFFFFFF, 1'b0};
    vecs[1]  = '{32'hFE512E23, 3'd1, 32'hFFFFFFFC, 1'b0};
    vecs[2]  = '{32'h001000EF, 3'd4, 32'h00000800, 1'b0};
    vecs[3]  = '{32'h800000B7, 3'd3, 32'h80000000, 1'b0};
    vecs[4]  = '{32'h800000B7, 3'd6, 32'h00000000, 1'b1};
    vecs[5]  = '{32'hFFFFFFFF, 3'd7, 32'h00000000, 1'b1};
    vecs[6]  = '{32'h80000063, 3'd2, 32'hFFFFF000, 1'b0};
    vecs[7]  = '{32'h00000FE3, 3'd2, 32'h0000081E, 1'b0};
    vecs[8]  = '{32'h800F8073, 3'd5, 32'h0000001F, 1'b0};
    vecs[9]  = '{32'h7FF00013, 3'd0, 32'h000007FF, 1'b0};
    vecs[10] = '{32'h00000FA3, 3'd1, 32'h0000001F, 1'b0};
    vecs[11] = '{32'h800000EF, 3'd4, 32'hFFF00000, 1'b0};
    vecs[12] = '{32'h12345037, 3'd3, 32'h12345000, 1'b0};

    rst_n         = 1'b0;
    flush         = 1'b0;
    b32.in_valid  = 1'b0;
    b32.instr     = '0;
    b32.imm_src   = '0;
    b32.in_tag    = '0;
    b32.out_ready = 1'b1;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_out_valid", b32.out_valid, 0);
    chk("rst_in_ready", b32.in_ready, 0);
    chk("rst_outputs", {b32.imm_ext, b32.out_tag, 31'b0, b32.imm_illegal}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", b32.in_ready, 1);

    // Decode table, streamed back-to-back.
    for (int i = 0; i < 13; i++) begin
      offer(vecs[i].ins, vecs[i].src, 32'(i + 100));
      @(negedge clk);
      chk("tbl_valid", b32.out_valid, 1);
      chk("tbl_imm32", b32.imm_ext, vecs[i].exp);
      chk("tbl_imm64", b64.imm_ext, {{32{vecs[i].exp[31]}}, vecs[i].exp});
      chk("tbl_ill", {b64.imm_illegal, b32.imm_illegal}, {vecs[i].ill, vecs[i].ill});
      chk("tbl_tag", b32.out_tag, 32'(i + 100));
    end
    b32.in_valid = 1'b0;
    @(negedge clk);
    chk("tbl_valid_one_cycle", b32.out_valid, 0);

    // Backpressure: tags 1..4 with the output stalled for the first cycles.
    next_tag = 1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      b32.out_ready = (c >= 4);
      if (next_tag <= 4) offer(32'h00100013 * next_tag, 3'd0, 32'(next_tag));
      else b32.in_valid = 1'b0;
      if (c == 3) begin
        chk("bp_in_ready_low", b32.in_ready, 0);
        chk("bp_accepts", 32'(next_tag - 1), 2);
        chk("bp_hold_tag", {b32.out_valid, b32.out_tag}, {1'b1, 32'd1});
      end
      if (b32.in_valid && b32.in_ready) next_tag++;
      if (b32.out_valid && b32.out_ready) rx.push_back(b32.out_tag);
    end
    chk("bp_rx_count", rx.size(), 4);
    for (int i = 0; i < 4; i++) begin
      ev = (i < rx.size()) ? rx[i] : 32'hDEAD;
      chk("bp_rx_order", ev, 32'(i + 1));
    end

    // Flush with M and K both occupied.
    @(negedge clk);
    b32.out_ready = 1'b0;
    offer(32'h0, 3'd0, 32'h51);
    @(negedge clk);
    offer(32'h0, 3'd0, 32'h52);
    @(negedge clk);
    chk("fl_full_ready", b32.in_ready, 0);
    chk("fl_full_tag", b32.out_tag, 32'h51);
    flush = 1'b1;
    offer(32'h0, 3'd0, 32'h53);
    @(negedge clk);
    chk("fl_out_valid", b32.out_valid, 0);
    chk("fl_in_ready", b32.in_ready, 1);
    flush         = 1'b0;
    b32.in_valid  = 1'b0;
    b32.out_ready = 1'b1;
    nout = 0;
    repeat (5) begin
      @(negedge clk);
      if (b32.out_valid) nout++;
    end
    chk("fl_no_stale", nout, 0);

    // Asynchronous reset in the middle of a stall.
    b32.out_ready = 1'b0;
    offer(32'hFFF00093, 3'd0, 32'h61);
    @(negedge clk);
    offer(32'hFFF00093, 3'd0, 32'h62);
    @(negedge clk);
    b32.in_valid = 1'b0;
    chk("rs_pre_valid", b32.out_valid, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("rs_async_valid", b32.out_valid, 0);
    chk("rs_async_outs", {b32.imm_ext, b32.out_tag, 31'b0, b32.imm_illegal}, 0);
    chk("rs_async_ready", b32.in_ready, 0);
    repeat (2) @(negedge clk);
    rst_n         = 1'b1;
    b32.out_ready = 1'b1;
    nout = 0;
    repeat (5) begin
      @(negedge clk);
      if (b32.out_valid) nout++;
    end
    chk("rs_no_stale", nout, 0);

    // Random traffic against the scoreboard.
    acc = 0;
    cyc = 0;
    while (acc < 10000 && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      b32.in_valid  = ($urandom % 4) != 0;
      b32.instr     = 25'($urandom);
      b32.imm_src   = 3'($urandom);
      b32.in_tag    = $urandom;
      b32.out_ready = ($urandom % 3) != 0;
      flush         = ($urandom_range(0, 199) == 0);
      if (b32.in_valid && b32.in_ready && !flush) acc++;
    end
    chk("rand_beats_done", acc >= 10000, 1);
    b32.in_valid  = 1'b0;
    flush         = 1'b0;
    b32.out_ready = 1'b1;
    repeat (4) @(negedge clk);
    #3;
    chk("rand_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
